// File: rtl/debug_slave_sampler.sv
// Single-clock virtual-JTAG debug slave: oversamples TCK/TDI/virtual states, shifts a per-channel DR
// and emits one-cycle action pulses on UDR. Optional parity check enabled by DEBUG_SLAVE_PARITY_EN.
module debug_slave_sampler #(
    parameter int DR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 tck,
    input  logic                                 tdi,
    output logic                                 tdo,
    input  logic                                 vs_cdr,
    input  logic                                 vs_sdr,
    input  logic                                 vs_uir,
    input  logic                                 vs_udr,
    input  logic [IR_WIDTH-1:0]                  ir_in,
    input  logic [(2**IR_WIDTH)*DR_WIDTH-1:0]    capture_data,
    output logic [DR_WIDTH-1:0]                  jdo,
    output logic [IR_WIDTH-1:0]                  ir_q,
    output logic [(2**IR_WIDTH)-1:0]             take_action,
    output logic [(2**IR_WIDTH)-1:0]             take_no_action,
    output logic                                 length_err
);

    localparam int NCH = 2**IR_WIDTH;
    localparam int SW  = IR_WIDTH + 6;
    localparam int CW  = $clog2(DR_WIDTH + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_UPD   = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    logic [SW-1:0]       pinVec;
    logic [SW-1:0]       sync_q [SYNC_STAGES];
    logic [IR_WIDTH-1:0] irInS;
    logic                udrS, uirS, sdrS, cdrS, tdiS, tckS;
    logic                tckPrev_q, uirPrev_q, udrPrev_q;
    logic                tckRise, tckFall, uirRise, udrRise;

    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]       shiftCnt_q, shiftCnt_d;
    logic                tdo_q, tdo_d;
    logic [IR_WIDTH-1:0] ir_d;
    logic [DR_WIDTH-1:0] capWord;

    logic [1:0]          state_q, state_d;
    logic                pending_q, pending_d;
    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic [IR_WIDTH-1:0] chan_q, chan_d;
    logic                bad_q, bad_d;
    logic [NCH-1:0]      act_q, act_d, noAct_q, noAct_d;
    logic                lenErr_q, lenErr_d;
    logic [NCH-1:0]      chanOneHot;
    logic                lenBad, parBad, load;

    assign pinVec = {ir_in, vs_udr, vs_uir, vs_sdr, vs_cdr, tdi, tck};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pinVec;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {irInS, udrS, uirS, sdrS, cdrS, tdiS, tckS} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            tckPrev_q <= 1'b0;
            uirPrev_q <= 1'b0;
            udrPrev_q <= 1'b0;
        end else begin
            tckPrev_q <= tckS;
            uirPrev_q <= uirS;
            udrPrev_q <= udrS;
        end
    end

    assign tckRise = tckS & ~tckPrev_q;
    assign tckFall = ~tckS & tckPrev_q;
    assign uirRise = uirS & ~uirPrev_q;
    assign udrRise = udrS & ~udrPrev_q;

    assign capWord = capture_data[int'(ir_q)*DR_WIDTH +: DR_WIDTH];

    // Capture wins over shift; the count saturates one past DR_WIDTH so overshifts stay detectable.
    always_comb begin
        sr_d       = sr_q;
        shiftCnt_d = shiftCnt_q;
        if (tckRise) begin
            if (cdrS) begin
                sr_d       = capWord;
                shiftCnt_d = '0;
            end else if (sdrS) begin
                sr_d = {tdiS, sr_q[DR_WIDTH-1:1]};
                if (shiftCnt_q != CW'(DR_WIDTH + 1)) shiftCnt_d = shiftCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tdo_d = tdo_q;
        ir_d  = ir_q;
        if (tckFall) tdo_d = sr_q[0];
        if (uirRise) ir_d = irInS;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            shiftCnt_q <= '0;
            tdo_q      <= 1'b0;
            ir_q       <= '0;
        end else begin
            sr_q       <= sr_d;
            shiftCnt_q <= shiftCnt_d;
            tdo_q      <= tdo_d;
            ir_q       <= ir_d;
        end
    end

    assign lenBad = (shiftCnt_q != CW'(DR_WIDTH));
`ifdef DEBUG_SLAVE_PARITY_EN
    assign parBad = ((^sr_q[DR_WIDTH-3:0]) != sr_q[DR_WIDTH-2]);
`else
    assign parBad = 1'b0;
`endif

    assign chanOneHot = NCH'(1) << chan_q;

    // Channel and verdict are frozen at the UDR edge, so a simultaneous UIR only affects later transfers.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        jdo_d     = jdo_q;
        chan_d    = chan_q;
        bad_d     = bad_q;
        act_d     = '0;
        noAct_d   = '0;
        lenErr_d  = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (udrRise) load = 1'b1;
            end
            ST_UPD: begin
                state_d = ST_PULSE;
                if (udrRise) pending_d = 1'b1;
                if (bad_q) lenErr_d = 1'b1;
                else if (jdo_q[DR_WIDTH-1]) act_d = chanOneHot;
                else noAct_d = chanOneHot;
            end
            ST_PULSE: begin
                if (pending_q || udrRise) begin
                    load      = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            jdo_d   = sr_q;
            chan_d  = ir_q;
            bad_d   = lenBad | parBad;
            state_d = ST_UPD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            jdo_q     <= '0;
            chan_q    <= '0;
            bad_q     <= 1'b0;
            act_q     <= '0;
            noAct_q   <= '0;
            lenErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            jdo_q     <= jdo_d;
            chan_q    <= chan_d;
            bad_q     <= bad_d;
            act_q     <= act_d;
            noAct_q   <= noAct_d;
            lenErr_q  <= lenErr_d;
        end
    end

    assign tdo            = tdo_q;
    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noAct_q;
    assign length_err     = lenErr_q;

endmodule
